// File: rtl/bank_accumulator.sv
// bank_accumulator: one output-buffer bank. Keeps products addressed to BANK_ID,
// accumulates them into a TILE_SIZE-entry memory through a 2-stage
// read-modify-write pipeline, and offers a clear sweep and an in-order drain stream.
// Optional build macro BANK_ACC_SATURATE_EN: saturating sums plus sticky sat_flag.
module bank_accumulator #(
   parameter int BANK_COUNT = 32,
   parameter int TILE_SIZE  = 256,
   parameter int BANK_ID    = 0,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [$clog2(BANK_COUNT)-1:0] in_bank,
   input  logic [$clog2(TILE_SIZE)-1:0]  in_entry,
   input  logic [DATA_WIDTH-1:0]         in_value,
   input  logic                          clear_req,
   input  logic                          drain_req,
   output logic                          drain_valid,
   input  logic                          drain_ready,
   output logic [$clog2(TILE_SIZE)-1:0]  drain_entry,
   output logic [ACC_WIDTH-1:0]          drain_data,
   output logic                          drain_done,
   output logic                          busy,
   output logic                          misroute
`ifdef BANK_ACC_SATURATE_EN
   ,
   output logic                          sat_flag
`endif
);

   localparam int BW  = $clog2(BANK_COUNT);
   localparam int EW  = $clog2(TILE_SIZE);
   localparam int FAW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

`ifdef BANK_ACC_SATURATE_EN
   // Clamp a one-bit-wider sum into the signed accumulator range.
   function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH:0] w);
      if (w[ACC_WIDTH] != w[ACC_WIDTH-1]) begin
         if (w[ACC_WIDTH]) return {1'b1, {(ACC_WIDTH-1){1'b0}}};
         else              return {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         return w[ACC_WIDTH-1:0];
      end
   endfunction

   // A wider sum overflowed when its two top bits disagree.
   function automatic logic acc_overflow(input logic [ACC_WIDTH:0] w);
      return w[ACC_WIDTH] ^ w[ACC_WIDTH-1];
   endfunction
`endif

   logic [1:0]            state_r;
   logic                  flush_clear_r;
   logic [EW-1:0]         clr_idx_r;
   logic [EW:0]           rd_idx_r;
   logic                  rd_pend_r;
   logic [EW-1:0]         pend_entry_r;

   logic [EW-1:0]         fifo_entry_r [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_value_r [FIFO_DEPTH];
   logic [FAW-1:0]        wr_ptr_r, rd_ptr_r;
   logic [FAW:0]          count_r;

   logic                  s1_valid_r, s2_valid_r;
   logic [EW-1:0]         s1_entry_r, s2_entry_r;
   logic [DATA_WIDTH-1:0] s1_value_r;
   logic [ACC_WIDTH-1:0]  s2_sum_r;

   logic [ACC_WIDTH-1:0]  mem_r [TILE_SIZE];
   logic [ACC_WIDTH-1:0]  rd_data_r;

   logic                  drain_valid_r, drain_done_r, misroute_r;
   logic [EW-1:0]         drain_entry_r;
   logic [ACC_WIDTH-1:0]  drain_data_r;

   logic fifo_full_s, fifo_empty_s, in_ready_s, accept_s, bank_hit_s, push_s, pop_s;
   logic pipe_empty_s, out_free_s, load_out_s, pend_keep_s, issue_s;
   logic accept_beat_s, last_beat_s, byp_s;
   logic [EW-1:0]         head_entry_s;
   logic [DATA_WIDTH-1:0] head_value_s;
   logic [ACC_WIDTH-1:0]  operand_s, sum_s;
   logic                  mem_we_s, mem_ren_s;
   logic [EW-1:0]         mem_waddr_s, mem_raddr_s;
   logic [ACC_WIDTH-1:0]  mem_wdata_s;

   assign fifo_full_s   = (count_r == (FAW+1)'(FIFO_DEPTH));
   assign fifo_empty_s  = (count_r == (FAW+1)'(0));
   assign in_ready_s    = (state_r == ST_ACCUM) && !fifo_full_s;
   assign accept_s      = in_valid && in_ready_s;
   assign bank_hit_s    = (in_bank == BW'(BANK_ID));
   assign push_s        = accept_s && bank_hit_s;
   assign pop_s         = !fifo_empty_s && ((state_r == ST_ACCUM) || (state_r == ST_FLUSH));
   assign head_entry_s  = fifo_entry_r[rd_ptr_r];
   assign head_value_s  = fifo_value_r[rd_ptr_r];
   assign pipe_empty_s  = fifo_empty_s && !s1_valid_r && !s2_valid_r;

   // Drain: one read may sit in rd_data_r while the output register is stalled.
   assign out_free_s    = !drain_valid_r || drain_ready;
   assign load_out_s    = rd_pend_r && out_free_s;
   assign pend_keep_s   = rd_pend_r && !out_free_s;
   assign issue_s       = (state_r == ST_DRAIN) && (rd_idx_r < (EW+1)'(TILE_SIZE)) && !pend_keep_s;
   assign accept_beat_s = drain_valid_r && drain_ready;
   assign last_beat_s   = accept_beat_s && (drain_entry_r == EW'(TILE_SIZE - 1));

   // Stage 2's sum is newer than the memory word stage 1 read for the same entry.
   assign operand_s = (s2_valid_r && (s2_entry_r == s1_entry_r)) ? s2_sum_r : rd_data_r;
   // A product popped this cycle must see stage 2's write landing on the same edge.
   assign byp_s     = (state_r != ST_DRAIN) && s2_valid_r && (s2_entry_r == head_entry_s);

`ifdef BANK_ACC_SATURATE_EN
   logic [ACC_WIDTH:0] wide_sum_s;
   logic               sat_hit_s;
   logic               sat_flag_r;
   assign wide_sum_s = (ACC_WIDTH+1)'($signed(operand_s)) + (ACC_WIDTH+1)'($signed(s1_value_r));
   assign sum_s      = sat_acc(wide_sum_s);
   assign sat_hit_s  = s1_valid_r && acc_overflow(wide_sum_s);
   assign sat_flag   = sat_flag_r;
`else
   assign sum_s = operand_s + ACC_WIDTH'($signed(s1_value_r));
`endif

   // Memory write/read port selection: clear sweep, pipeline write-back, drain reads.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = s2_entry_r;
      mem_wdata_s = s2_sum_r;
      if (state_r == ST_CLEAR) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = clr_idx_r;
         mem_wdata_s = {ACC_WIDTH{1'b0}};
      end else if (s2_valid_r) begin
         mem_we_s    = 1'b1;
      end else begin
         mem_we_s    = 1'b0;
      end
      if (state_r == ST_DRAIN) begin
         mem_raddr_s = rd_idx_r[EW-1:0];
         mem_ren_s   = issue_s;
      end else begin
         mem_raddr_s = head_entry_s;
         mem_ren_s   = pop_s;
      end
   end

   // Accumulator memory (not reset) with one registered read port.
   always_ff @(posedge clk) begin
      if (mem_we_s) mem_r[mem_waddr_s] <= mem_wdata_s;
      if (mem_ren_s) rd_data_r <= byp_s ? s2_sum_r : mem_r[mem_raddr_s];
   end

   // Input queue payload storage.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_entry_r[wr_ptr_r] <= in_entry;
         fifo_value_r[wr_ptr_r] <= in_value;
      end
   end

   // Input queue pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {FAW{1'b0}};
         rd_ptr_r <= {FAW{1'b0}};
         count_r  <= {(FAW+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + FAW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + FAW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (FAW+1)'(1);
            2'b01:   count_r <= count_r - (FAW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Read-modify-write pipeline: stage 1 holds the popped product, stage 2 the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_entry_r <= {EW{1'b0}};
         s1_value_r <= {DATA_WIDTH{1'b0}};
         s2_valid_r <= 1'b0;
         s2_entry_r <= {EW{1'b0}};
         s2_sum_r   <= {ACC_WIDTH{1'b0}};
      end else begin
         s1_valid_r <= pop_s;
         if (pop_s) begin
            s1_entry_r <= head_entry_s;
            s1_value_r <= head_value_s;
         end
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_entry_r <= s1_entry_r;
            s2_sum_r   <= sum_s;
         end
      end
   end

   // Control FSM: clear sweep, accumulate, flush in-flight work, drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_CLEAR;
         flush_clear_r <= 1'b0;
         clr_idx_r     <= {EW{1'b0}};
         rd_idx_r      <= {(EW+1){1'b0}};
      end else begin
         case (state_r)
            ST_CLEAR: begin
               if (clear_req)                             clr_idx_r <= {EW{1'b0}};
               else if (clr_idx_r == EW'(TILE_SIZE - 1))  state_r   <= ST_ACCUM;
               else                                       clr_idx_r <= clr_idx_r + EW'(1);
            end
            ST_ACCUM: begin
               if (drain_req) begin
                  state_r       <= ST_FLUSH;
                  flush_clear_r <= 1'b0;
               end else if (clear_req) begin
                  state_r       <= ST_FLUSH;
                  flush_clear_r <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (pipe_empty_s) begin
                  if (flush_clear_r) begin
                     state_r   <= ST_CLEAR;
                     clr_idx_r <= {EW{1'b0}};
                  end else begin
                     state_r  <= ST_DRAIN;
                     rd_idx_r <= {(EW+1){1'b0}};
                  end
               end
            end
            ST_DRAIN: begin
               if (issue_s)     rd_idx_r <= rd_idx_r + (EW+1)'(1);
               if (last_beat_s) state_r  <= ST_ACCUM;
            end
            default: state_r <= ST_CLEAR;
         endcase
      end
   end

   // Drain output register, pending-read tracking and completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_r     <= 1'b0;
         pend_entry_r  <= {EW{1'b0}};
         drain_valid_r <= 1'b0;
         drain_entry_r <= {EW{1'b0}};
         drain_data_r  <= {ACC_WIDTH{1'b0}};
         drain_done_r  <= 1'b0;
      end else begin
         rd_pend_r <= issue_s || pend_keep_s;
         if (issue_s) pend_entry_r <= rd_idx_r[EW-1:0];
         if (load_out_s) begin
            drain_valid_r <= 1'b1;
            drain_entry_r <= pend_entry_r;
            drain_data_r  <= rd_data_r;
         end else if (accept_beat_s) begin
            drain_valid_r <= 1'b0;
         end
         drain_done_r <= last_beat_s;
      end
   end

   // Sticky flag for accepted products addressed to another bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      misroute_r <= 1'b0;
      else if (accept_s && !bank_hit_s) misroute_r <= 1'b1;
   end

`ifdef BANK_ACC_SATURATE_EN
   // Sticky saturation flag, cleared by a clear request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         sat_flag_r <= 1'b0;
      else if (clear_req) sat_flag_r <= 1'b0;
      else if (sat_hit_s) sat_flag_r <= 1'b1;
   end
`endif

   assign in_ready    = in_ready_s;
   assign drain_valid = drain_valid_r;
   assign drain_entry = drain_entry_r;
   assign drain_data  = drain_data_r;
   assign drain_done  = drain_done_r;
   assign misroute    = misroute_r;
   assign busy        = (state_r != ST_ACCUM) || !pipe_empty_s;

endmodule

// File: tb/tb_bank_accumulator.sv
// Self-checking bench for bank_accumulator (BANK_ID=3). A behavioural array model
// predicts every entry; drains push expected beats into a queue that a negedge
// monitor pops and compares. Honours BANK_ACC_SATURATE_EN when defined.
module tb_bank_accumulator;
   localparam int TILE = 256;
   localparam int BID  = 3;
   localparam int ACC_MAX = 8388607;
   localparam int ACC_MIN = -8388608;

   logic        clk, rst_n, in_valid, in_ready;
   logic [4:0]  in_bank;
   logic [7:0]  in_entry;
   logic [15:0] in_value;
   logic        clear_req, drain_req, drain_valid, drain_ready, drain_done, busy, misroute;
   logic [7:0]  drain_entry;
   logic [23:0] drain_data;
`ifdef BANK_ACC_SATURATE_EN
   logic        sat_flag;
`endif

   bank_accumulator #(.BANK_COUNT(32), .TILE_SIZE(TILE), .BANK_ID(BID),
                      .DATA_WIDTH(16), .ACC_WIDTH(24), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_bank(in_bank), .in_entry(in_entry), .in_value(in_value),
      .clear_req(clear_req), .drain_req(drain_req), .drain_valid(drain_valid),
      .drain_ready(drain_ready), .drain_entry(drain_entry), .drain_data(drain_data),
      .drain_done(drain_done), .busy(busy), .misroute(misroute)
`ifdef BANK_ACC_SATURATE_EN
      , .sat_flag(sat_flag)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int model [TILE];
   bit exp_misroute;
   int exp_entry_q[$];
   int exp_data_q[$];
   bit done_expect;
   int done_seen = 0;
   bit prev_stall;
   logic [7:0]  prev_entry;
   logic [23:0] prev_data;

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference accumulation: plain integer sum, then wrap or clamp to 24 bits.
   function automatic int acc_model(input int a, input int v);
      longint s;
      s = longint'(a) + longint'(v);
`ifdef BANK_ACC_SATURATE_EN
      if (s > ACC_MAX) s = ACC_MAX;
      if (s < ACC_MIN) s = ACC_MIN;
`else
      s = s & 64'h0000_0000_00FF_FFFF;
      if (s > ACC_MAX) s = s - 64'sd16777216;
`endif
      return int'(s);
   endfunction

   // Monitor: compares every accepted drain beat, hold behaviour and done pulses.
   always @(negedge clk) begin : mon
      int e, d, got;
      if (rst_n) begin
         if (done_expect) begin
            check("drain_done", drain_done, 1);
            done_expect = 1'b0;
            done_seen++;
         end else if (drain_done) begin
            check("drain_done_spurious", drain_done, 0);
         end
         if (prev_stall) begin
            check("hold_valid", drain_valid, 1);
            check("hold_entry", drain_entry, prev_entry);
            check("hold_data", drain_data, prev_data);
         end
         if (drain_valid && drain_ready) begin
            if (exp_entry_q.size() == 0) begin
               check("unexpected_beat_entry", drain_entry, -1);
            end else begin
               e = exp_entry_q.pop_front();
               d = exp_data_q.pop_front();
               got = $signed(drain_data);
               check("beat_entry", drain_entry, e);
               check("beat_data", got, d);
               if (e == TILE - 1) done_expect = 1'b1;
            end
         end
         prev_stall = drain_valid && !drain_ready;
         prev_entry = drain_entry;
         prev_data  = drain_data;
      end else begin
         prev_stall  = 1'b0;
         done_expect = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || !in_ready) && n < 1000) begin
         tick();
         n++;
      end
      check("idle_reached", n < 1000, 1);
   endtask

   task automatic push(input int bank, input int entry, input int value);
      int n = 0;
      bit acc;
      in_valid = 1'b1;
      in_bank  = 5'(bank);
      in_entry = 8'(entry);
      in_value = 16'(value);
      do begin
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 100);
      in_valid = 1'b0;
      if (acc) begin
         if (bank == BID) model[entry] = acc_model(model[entry], value);
         else             exp_misroute = 1'b1;
      end else begin
         check("push_accepted", acc, 1);
      end
   endtask

   // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
   task automatic do_drain(input int mode, input bit also_clear);
      int n = 0;
      int start_done;
      for (int i = 0; i < TILE; i++) begin
         exp_entry_q.push_back(i);
         exp_data_q.push_back(model[i]);
      end
      start_done  = done_seen;
      drain_ready = 1'b1;
      drain_req   = 1'b1;
      clear_req   = also_clear;
      tick();
      drain_req = 1'b0;
      clear_req = 1'b0;
      while (done_seen == start_done && n < 3000) begin
         case (mode)
            1:       drain_ready = ((n % 4) == 0) || ((n % 4) == 3);
            2:       drain_ready = 1'($urandom_range(0, 1));
            default: drain_ready = 1'b1;
         endcase
         tick();
         n++;
      end
      check("drain_completed", done_seen - start_done, 1);
      check("drain_queue_empty", exp_entry_q.size(), 0);
      drain_ready = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      bit busy_dropped;
      logic [15:0] rv;
      rst_n = 1'b0; in_valid = 1'b0; in_bank = 5'd0; in_entry = 8'd0; in_value = 16'd0;
      clear_req = 1'b0; drain_req = 1'b0; drain_ready = 1'b0;
      exp_misroute = 1'b0; done_expect = 1'b0; prev_stall = 1'b0;
      for (int i = 0; i < TILE; i++) model[i] = 0;
      repeat (3) tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_drain_valid", drain_valid, 0);
      check("rst_drain_entry", drain_entry, 0);
      check("rst_drain_data", drain_data, 0);
      check("rst_drain_done", drain_done, 0);
      check("rst_misroute", misroute, 0);
      check("rst_busy", busy, 1);

      // Clear sweep length after reset release.
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      busy_dropped = 1'b0;
      while (!in_ready && n < 400) begin
         if (!busy) busy_dropped = 1'b1;
         tick();
         n++;
      end
      check("clear_cycles", n, 256);
      check("busy_during_clear", busy_dropped, 0);
      check("busy_after_clear", busy, 0);
      do_drain(0, 1'b0);

      // Back-to-back same-entry products need forwarding.
      push(BID, 5, 7);
      push(BID, 5, -2);
      do_drain(0, 1'b0);

      // Burst to one entry.
      for (int i = 0; i < 10; i++) push(BID, 0, 100);
      do_drain(1, 1'b0);

      // Misrouted product is dropped and flagged sticky.
      check("misroute_before", misroute, 0);
      push(7, 1, 9);
      tick();
      check("misroute_set", misroute, 1);
      repeat (5) tick();
      check("misroute_sticky", misroute, 1);
      do_drain(2, 1'b0);

      // Randomized products, clustered on a few entries to stress hazards.
      for (int i = 0; i < 300; i++) begin
         rv = 16'($urandom);
         push(($urandom_range(0, 7) == 0) ? 7 : BID,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TILE - 1)) : int'($urandom_range(0, 3)),
              int'($signed(rv)));
         if ($urandom_range(0, 3) == 0) tick();
      end
      do_drain(2, 1'b0);

      // Drain and clear together: drain wins, contents survive.
      push(BID, 4, 11);
      do_drain(1, 1'b1);

      // Clear with products still in flight.
      push(BID, 9, 50);
      push(BID, 10, 60);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < TILE; i++) model[i] = 0;
      check("busy_after_clear_req", busy, 1);
      wait_idle();
      do_drain(0, 1'b0);

      // Reset in the middle of a drain.
      push(BID, 40, 123);
      for (int i = 0; i < TILE; i++) begin
         exp_entry_q.push_back(i);
         exp_data_q.push_back(model[i]);
      end
      drain_ready = 1'b1;
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(drain_valid && drain_entry == 8'd40) && n < 1000);
      check("reached_entry40", drain_valid && drain_entry == 8'd40, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_drain_valid", drain_valid, 0);
      check("midreset_busy", busy, 1);
      check("midreset_in_ready", in_ready, 0);
      check("midreset_misroute", misroute, 0);
      exp_entry_q.delete();
      exp_data_q.delete();
      exp_misroute = 1'b0;
      for (int i = 0; i < TILE; i++) model[i] = 0;
      drain_ready = 1'b0;
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      wait_idle();
      do_drain(0, 1'b0);

`ifdef BANK_ACC_SATURATE_EN
      check("sat_flag_clear", sat_flag, 0);
      for (int i = 0; i < 300; i++) push(BID, 2, 32767);
      do_drain(0, 1'b0);
      check("sat_entry2", model[2], ACC_MAX);
      check("sat_flag_set", sat_flag, 1);
`endif

      check("misroute_final", misroute, exp_misroute);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
